lab4_mcore_mem_port_arbiter: RTL and testbench

Shares one 16B memory port between the instruction-cache refill port and the data-cache refill port of a single core, so a core plus its two blocking caches needs only one connection to the memory system or network. Requests are granted round-robin with a grant lock that keeps the presented message stable under backpressure. Responses are steered back in order through an internal requester-ID FIFO. The arbiter adds no latency: request and response paths are combinational pass-throughs gated by arbitration state.

---
 rtl/lab4_mcore_mem_port_arbiter_if.sv | 66 ++++++
 rtl/lab4_mcore_mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_lab4_mcore_mem_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lab4_mcore_mem_port_arbiter_if.sv
// Message types and the bundled request/response bus shared by the icache,
// dcache and memory sides of the single-core memory port arbiter.
package lab4_mcore_mem_port_arbiter_pkg;

  typedef struct packed {
    logic [2:0]   typ;
    logic [7:0]   opaque;
    logic [31:0]  addr;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_req_16B_t;

  typedef struct packed {
    logic [2:0]   typ;
    logic [7:0]   opaque;
    logic [1:0]   test;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_resp_16B_t;

endpackage

interface lab4_mcore_mem_port_arbiter_if;

  lab4_mcore_mem_port_arbiter_pkg::mem_req_16B_t  req0_msg;
  logic                                           req0_val;
  logic                                           req0_rdy;
  lab4_mcore_mem_port_arbiter_pkg::mem_req_16B_t  req1_msg;
  logic                                           req1_val;
  logic                                           req1_rdy;
  lab4_mcore_mem_port_arbiter_pkg::mem_resp_16B_t resp0_msg;
  logic                                           resp0_val;
  logic                                           resp0_rdy;
  lab4_mcore_mem_port_arbiter_pkg::mem_resp_16B_t resp1_msg;
  logic                                           resp1_val;
  logic                                           resp1_rdy;
  lab4_mcore_mem_port_arbiter_pkg::mem_req_16B_t  memreq_msg;
  logic                                           memreq_val;
  logic                                           memreq_rdy;
  lab4_mcore_mem_port_arbiter_pkg::mem_resp_16B_t memresp_msg;
  logic                                           memresp_val;
  logic                                           memresp_rdy;
  logic                                           arb_conflict;

  // master: the environment (caches and memory); slave: the arbiter
  modport master (
    output req0_msg, req0_val, input req0_rdy,
    output req1_msg, req1_val, input req1_rdy,
    input  resp0_msg, resp0_val, output resp0_rdy,
    input  resp1_msg, resp1_val, output resp1_rdy,
    input  memreq_msg, memreq_val, output memreq_rdy,
    output memresp_msg, memresp_val, input memresp_rdy,
    input  arb_conflict
  );

  modport slave (
    input  req0_msg, req0_val, output req0_rdy,
    input  req1_msg, req1_val, output req1_rdy,
    output resp0_msg, resp0_val, input resp0_rdy,
    output resp1_msg, resp1_val, input resp1_rdy,
    output memreq_msg, memreq_val, input memreq_rdy,
    input  memresp_msg, memresp_val, output memresp_rdy,
    output arb_conflict
  );

endinterface

// File: rtl/lab4_mcore_mem_port_arbiter.sv
// Zero-latency round-robin arbiter sharing one 16B memory port between the
// icache and dcache refill ports; responses are steered back via an ID FIFO.
module lab4_mcore_mem_port_arbiter #(
  parameter int p_max_outstanding = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  lab4_mcore_mem_port_arbiter_if.slave bus
);

  localparam int PW = (p_max_outstanding > 1) ? $clog2(p_max_outstanding) : 1;
  localparam int CW = $clog2(p_max_outstanding + 1);

  logic          prio_q, prio_d;
  logic          lock_q, lock_d;
  logic          lock_id_q, lock_id_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          id_mem_q [p_max_outstanding];

  logic grant;
  logic gnt_val;
  logic fifo_full;
  logic fifo_empty;
  logic head_id;
  logic push;
  logic pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(p_max_outstanding - 1)) ? '0 : ptr + PW'(1);
  endfunction

  assign fifo_full  = (cnt_q == CW'(p_max_outstanding));
  assign fifo_empty = (cnt_q == '0);
  assign head_id    = id_mem_q[head_q];

  // A held grant wins over everything so the presented message stays stable.
  always_comb begin
    grant = 1'b0;
    if (lock_q)
      grant = lock_id_q;
    else if (bus.req0_val && bus.req1_val)
      grant = prio_q;
    else if (bus.req1_val)
      grant = 1'b1;
  end

  assign gnt_val = grant ? bus.req1_val : bus.req0_val;

  assign bus.memreq_msg   = grant ? bus.req1_msg : bus.req0_msg;
  assign bus.memreq_val   = ~reset & gnt_val & ~fifo_full;
  assign bus.req0_rdy     = ~reset & ~grant & bus.memreq_rdy & ~fifo_full;
  assign bus.req1_rdy     = ~reset &  grant & bus.memreq_rdy & ~fifo_full;
  assign bus.arb_conflict = ~reset & bus.req0_val & bus.req1_val & ~lock_q;

  assign bus.resp0_msg   = bus.memresp_msg;
  assign bus.resp1_msg   = bus.memresp_msg;
  assign bus.resp0_val   = ~reset & ~fifo_empty & ~head_id & bus.memresp_val;
  assign bus.resp1_val   = ~reset & ~fifo_empty &  head_id & bus.memresp_val;
  assign bus.memresp_rdy = ~reset & ~fifo_empty &
                           (head_id ? bus.resp1_rdy : bus.resp0_rdy);

  assign push = bus.memreq_val & bus.memreq_rdy;
  assign pop  = bus.memresp_val & bus.memresp_rdy;

  always_comb begin
    prio_d    = prio_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    head_d    = head_q;
    tail_d    = tail_q;
    cnt_d     = cnt_q;

    if (push) begin
      prio_d = ~grant;
      lock_d = 1'b0;
      tail_d = ptr_inc(tail_q);
    end else if (bus.memreq_val) begin
      lock_d    = 1'b1;
      lock_id_d = grant;
    end

    if (pop)
      head_d = ptr_inc(head_q);

    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q    <= 1'b0;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= '0;
    end else begin
      prio_q    <= prio_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
    end
  end

  // ID storage holds data only; validity comes from the reset-cleared count.
  always_ff @(posedge clk) begin
    if (push)
      id_mem_q[tail_q] <= grant;
  end

endmodule

// File: tb/tb_lab4_mcore_mem_port_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a queue-based arbiter model.
module tb_lab4_mcore_mem_port_arbiter;
  import lab4_mcore_mem_port_arbiter_pkg::*;

  localparam int DEPTH_A = 3;
  localparam int DEPTH_B = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lab4_mcore_mem_port_arbiter_if ifa ();
  lab4_mcore_mem_port_arbiter_if ifb ();

  lab4_mcore_mem_port_arbiter #(.p_max_outstanding(DEPTH_A)) dut_a (
    .clk(clk), .reset(rst), .bus(ifa.slave)
  );
  lab4_mcore_mem_port_arbiter #(.p_max_outstanding(DEPTH_B)) dut_b (
    .clk(clk), .reset(rst), .bus(ifb.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic mem_req_16B_t rand_req();
    mem_req_16B_t m;
    m.typ    = 3'($urandom_range(0, 7));
    m.opaque = 8'($urandom_range(0, 255));
    m.addr   = $urandom;
    m.len    = 4'($urandom_range(0, 15));
    m.data   = {$urandom, $urandom, $urandom, $urandom};
    return m;
  endfunction

  function automatic mem_resp_16B_t rand_resp();
    mem_resp_16B_t m;
    m.typ    = 3'($urandom_range(0, 7));
    m.opaque = 8'($urandom_range(0, 255));
    m.test   = 2'($urandom_range(0, 3));
    m.len    = 4'($urandom_range(0, 15));
    m.data   = {$urandom, $urandom, $urandom, $urandom};
    return m;
  endfunction

  // Behavioural model of dut_a: who is owed the port, who is favoured, and
  // the ordered list of requesters still waiting for a response.
  int   m_ids[$];
  bit   m_fav;
  bit   m_held;
  bit   m_held_id;
  bit   g, room, e_mval, e_r0rdy, e_r1rdy, e_rv0, e_rv1, e_mrdy, e_conf, head;

  always @(negedge clk) begin
    if (rst) begin
      chk1("rst_memreq_val", ifa.memreq_val, 1'b0);
      chk1("rst_req0_rdy", ifa.req0_rdy, 1'b0);
      chk1("rst_req1_rdy", ifa.req1_rdy, 1'b0);
      chk1("rst_resp0_val", ifa.resp0_val, 1'b0);
      chk1("rst_resp1_val", ifa.resp1_val, 1'b0);
      chk1("rst_memresp_rdy", ifa.memresp_rdy, 1'b0);
      chk1("rst_conflict", ifa.arb_conflict, 1'b0);
      m_ids.delete();
      m_fav  = 1'b0;
      m_held = 1'b0;
    end else begin
      if (m_held) g = m_held_id;
      else if (ifa.req0_val && ifa.req1_val) g = m_fav;
      else g = ifa.req1_val;
      room    = (m_ids.size() < DEPTH_A);
      e_mval  = (g ? ifa.req1_val : ifa.req0_val) && room;
      e_r0rdy = !g && ifa.memreq_rdy && room;
      e_r1rdy =  g && ifa.memreq_rdy && room;
      head    = (m_ids.size() > 0) ? (m_ids[0] == 1) : 1'b0;
      e_rv0   = (m_ids.size() > 0) && !head && ifa.memresp_val;
      e_rv1   = (m_ids.size() > 0) &&  head && ifa.memresp_val;
      e_mrdy  = (m_ids.size() > 0) && (head ? ifa.resp1_rdy : ifa.resp0_rdy);
      e_conf  = ifa.req0_val && ifa.req1_val && !m_held;

      chk1("memreq_val", ifa.memreq_val, e_mval);
      chk1("req0_rdy", ifa.req0_rdy, e_r0rdy);
      chk1("req1_rdy", ifa.req1_rdy, e_r1rdy);
      chk1("resp0_val", ifa.resp0_val, e_rv0);
      chk1("resp1_val", ifa.resp1_val, e_rv1);
      chk1("memresp_rdy", ifa.memresp_rdy, e_mrdy);
      chk1("arb_conflict", ifa.arb_conflict, e_conf);
      if (e_mval)
        chkw("memreq_msg", 192'(ifa.memreq_msg), 192'(g ? ifa.req1_msg : ifa.req0_msg));
      if (e_rv0) chkw("resp0_msg", 192'(ifa.resp0_msg), 192'(ifa.memresp_msg));
      if (e_rv1) chkw("resp1_msg", 192'(ifa.resp1_msg), 192'(ifa.memresp_msg));

      if (ifa.memresp_val && e_mrdy) void'(m_ids.pop_front());
      if (e_mval && ifa.memreq_rdy) begin
        m_ids.push_back(int'(g));
        m_fav  = !g;
        m_held = 1'b0;
      end else if (e_mval) begin
        m_held    = 1'b1;
        m_held_id = g;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    ifa.req0_val = 0; ifa.req1_val = 0; ifa.memreq_rdy = 0;
    ifa.memresp_val = 0; ifa.resp0_rdy = 0; ifa.resp1_rdy = 0;
  endtask

  task automatic idle_b();
    ifb.req0_val = 0; ifb.req1_val = 0; ifb.memreq_rdy = 0;
    ifb.memresp_val = 0; ifb.resp0_rdy = 0; ifb.resp1_rdy = 0;
    ifb.req0_msg = '0; ifb.req1_msg = '0; ifb.memresp_msg = '0;
  endtask

  // One reset cycle with every input asserted; outputs must all read 0.
  task automatic do_reset();
    step();
    rst = 1'b1;
    ifa.req0_val = 1; ifa.req1_val = 1; ifa.memreq_rdy = 1;
    ifa.memresp_val = 1; ifa.resp0_rdy = 1; ifa.resp1_rdy = 1;
    #1;
    chk1("reset_memreq_val", ifa.memreq_val, 1'b0);
    chk1("reset_req0_rdy", ifa.req0_rdy, 1'b0);
    chk1("reset_memresp_rdy", ifa.memresp_rdy, 1'b0);
    chk1("reset_conflict", ifa.arb_conflict, 1'b0);
    step();
    rst = 1'b0;
    idle_a();
  endtask

  initial begin
    idle_a();
    idle_b();
    ifa.req0_msg = '0; ifa.req1_msg = '0; ifa.memresp_msg = '0;
    repeat (2) step();
    do_reset();

    // Single requester, then its response
    ifa.req0_msg = '0;
    ifa.req0_msg.addr = 32'h1000;
    ifa.req0_val = 1; ifa.memreq_rdy = 1;
    #1;
    chkw("single_addr", 192'(ifa.memreq_msg.addr), 192'(32'h1000));
    chk1("single_req0_rdy", ifa.req0_rdy, 1'b1);
    chk1("single_memreq_val", ifa.memreq_val, 1'b1);
    step();
    idle_a();
    ifa.memresp_msg = '0;
    ifa.memresp_msg.data = {16{8'hAA}};
    ifa.memresp_val = 1; ifa.resp0_rdy = 1;
    #1;
    chk1("single_resp0_val", ifa.resp0_val, 1'b1);
    chk1("single_resp1_val", ifa.resp1_val, 1'b0);
    chkw("single_resp_data", 192'(ifa.resp0_msg.data), 192'({16{8'hAA}}));
    step();
    idle_a();

    // Round-robin with both requesters streaming
    do_reset();
    ifa.req0_msg = '0; ifa.req0_msg.opaque = 8'h00;
    ifa.req1_msg = '0; ifa.req1_msg.opaque = 8'h01;
    for (int k = 0; k < 4; k++) begin
      ifa.req0_val = 1; ifa.req1_val = 1; ifa.memreq_rdy = 1;
      ifa.memresp_val = (k >= 1); ifa.resp0_rdy = 1; ifa.resp1_rdy = 1;
      #1;
      chkw("rr_grant", 192'(ifa.memreq_msg.opaque), 192'(k % 2));
      chk1("rr_conflict", ifa.arb_conflict, 1'b1);
      if (k >= 1) begin
        chk1("rr_resp0_val", ifa.resp0_val, ((k - 1) % 2) == 0);
        chk1("rr_resp1_val", ifa.resp1_val, ((k - 1) % 2) == 1);
      end
      step();
    end
    idle_a();
    ifa.memresp_val = 1; ifa.resp0_rdy = 1; ifa.resp1_rdy = 1;
    #1;
    chk1("rr_last_resp1", ifa.resp1_val, 1'b1);
    step();
    idle_a();

    // Grant lock under backpressure
    do_reset();
    ifa.req1_val = 1;
    #1;
    chkw("lock_c0_msg", 192'(ifa.memreq_msg.opaque), 192'(1));
    chk1("lock_c0_val", ifa.memreq_val, 1'b1);
    chk1("lock_c0_req1_rdy", ifa.req1_rdy, 1'b0);
    for (int k = 1; k < 3; k++) begin
      step();
      ifa.req0_val = 1;
      #1;
      chkw("lock_stall_msg", 192'(ifa.memreq_msg.opaque), 192'(1));
      chk1("lock_stall_req0_rdy", ifa.req0_rdy, 1'b0);
      chk1("lock_stall_conflict", ifa.arb_conflict, 1'b0);
    end
    step();
    ifa.memreq_rdy = 1;
    #1;
    chkw("lock_fire1_msg", 192'(ifa.memreq_msg.opaque), 192'(1));
    chk1("lock_fire1_rdy", ifa.req1_rdy, 1'b1);
    step();
    ifa.req1_val = 0;
    #1;
    chkw("lock_fire0_msg", 192'(ifa.memreq_msg.opaque), 192'(0));
    chk1("lock_fire0_rdy", ifa.req0_rdy, 1'b1);
    step();
    idle_a();

    // Response backpressure: head is the dcache entry
    ifa.memresp_val = 1; ifa.resp0_rdy = 1; ifa.resp1_rdy = 0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk1("rbp_memresp_rdy", ifa.memresp_rdy, 1'b0);
      chk1("rbp_resp1_val", ifa.resp1_val, 1'b1);
      chk1("rbp_resp0_val", ifa.resp0_val, 1'b0);
      step();
    end
    ifa.resp1_rdy = 1;
    #1;
    chk1("rbp_pop_rdy", ifa.memresp_rdy, 1'b1);
    step();
    #1;
    chk1("rbp_next_resp0", ifa.resp0_val, 1'b1);
    chk1("rbp_next_resp1", ifa.resp1_val, 1'b0);
    step();
    idle_a();

    // Reset with two requests in flight
    ifa.req0_val = 1; ifa.memreq_rdy = 1;
    step();
    step();
    do_reset();
    ifa.memresp_val = 1; ifa.resp0_rdy = 1; ifa.resp1_rdy = 1;
    #1;
    chk1("postrst_memresp_rdy", ifa.memresp_rdy, 1'b0);
    chk1("postrst_resp0_val", ifa.resp0_val, 1'b0);
    step();
    idle_a();

    // Full FIFO on the depth-2 instance
    ifb.req0_val = 1; ifb.memreq_rdy = 1;
    for (int k = 0; k < 2; k++) begin
      ifb.req0_msg.opaque = 8'(k);
      #1;
      chk1("full_fire_val", ifb.memreq_val, 1'b1);
      chk1("full_fire_rdy", ifb.req0_rdy, 1'b1);
      step();
    end
    ifb.req0_msg.opaque = 8'h02;
    #1;
    chk1("full_block_rdy", ifb.req0_rdy, 1'b0);
    chk1("full_block_val", ifb.memreq_val, 1'b0);
    step();
    ifb.memresp_val = 1; ifb.resp0_rdy = 1;
    #1;
    chk1("full_pop_rdy", ifb.memresp_rdy, 1'b1);
    chk1("full_pop_resp0", ifb.resp0_val, 1'b1);
    chk1("full_nopush_val", ifb.memreq_val, 1'b0);
    chk1("full_nopush_rdy", ifb.req0_rdy, 1'b0);
    step();
    ifb.memresp_val = 0;
    #1;
    chk1("full_after_val", ifb.memreq_val, 1'b1);
    chk1("full_after_rdy", ifb.req0_rdy, 1'b1);
    chkw("full_after_msg", 192'(ifb.memreq_msg.opaque), 192'(2));
    step();
    idle_b();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 249) == 0);
      ifa.req0_val    = ($urandom_range(0, 2) != 0);
      ifa.req1_val    = ($urandom_range(0, 2) != 0);
      ifa.memreq_rdy  = ($urandom_range(0, 3) != 0);
      ifa.memresp_val = ($urandom_range(0, 1) != 0);
      ifa.resp0_rdy   = ($urandom_range(0, 3) != 0);
      ifa.resp1_rdy   = ($urandom_range(0, 3) != 0);
      ifa.req0_msg    = rand_req();
      ifa.req1_msg    = rand_req();
      ifa.memresp_msg = rand_resp();
      step();
    end
    rst = 1'b0;
    idle_a();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
